// File: rtl/instr_encoder_pkg.sv
// Shared encodings for the program loader: op classes, RV32I major opcodes,
// the canonical NOP word and the loader FSM states.
package instr_enc_pkg;

   typedef enum logic [2:0] {
      OP_R      = 3'd0,
      OP_I      = 3'd1,
      OP_LOAD   = 3'd2,
      OP_STORE  = 3'd3,
      OP_BRANCH = 3'd4
   } op_class_e;

   // Major opcodes, kept identical to the ones the control decoder matches on
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_PAD  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// Request channel into the instruction encoder: decoded fields plus
// valid/ready handshake and the end-of-program strobe.
interface instr_encoder_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  op;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [12:0] imm;
   logic        finish;

   modport master (
      output req_valid, op, rd, rs1, rs2, funct3, funct7, imm, finish,
      input  req_ready
   );

   modport slave (
      input  req_valid, op, rd, rs1, rs2, funct3, funct7, imm, finish,
      output req_ready
   );
endinterface

// File: rtl/instr_encoder_field_pack.sv
// Combinational packer: decoded fields to a 32-bit RV32I word, plus a flag
// for op classes that have no encoding here.
module instr_field_pack
   import instr_enc_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [12:0] imm,
   output logic [31:0] word,
   output logic        illegal
);

   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (op)
         OP_R:      word = {funct7, rs2, rs1, funct3, rd, OPC_OP};
         OP_I:      word = {imm[11:0], rs1, funct3, rd, OPC_OP_IMM};
         OP_LOAD:   word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
         OP_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
         // Branch offsets are halfword-aligned, so imm[0] never reaches the word
         OP_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, funct3,
                            imm[4:1], imm[11], OPC_BRANCH};
         default:   illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// On-chip program loader: packs decoded requests into RV32I words and writes
// them sequentially to instruction memory. Define INSTR_ENCODER_NOP_PAD_EN to
// fill the remaining memory with NOPs after finish.
module instr_encoder
   import instr_enc_pkg::*;
#(
   parameter int IMEM_DEPTH = 256,
   parameter int ADDR_W     = 32,
   localparam int CW        = $clog2(IMEM_DEPTH) + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   instr_encoder_if.slave    req,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_data_o,
   output logic [CW-1:0]     count_o,
   output logic              full_o,
   output logic              done_o,
   output logic              err_o
);

   localparam logic [CW-1:0] DEPTH_C = CW'(IMEM_DEPTH);

   state_e            state_reg;
   logic [31:0]       packed_word;
   logic              illegal_op;
   logic              accept;
   logic [CW-1:0]     count_inc;
   logic [ADDR_W-1:0] addr_cur;

   instr_field_pack u_pack (
      .op      (req.op),
      .rd      (req.rd),
      .rs1     (req.rs1),
      .rs2     (req.rs2),
      .funct3  (req.funct3),
      .funct7  (req.funct7),
      .imm     (req.imm),
      .word    (packed_word),
      .illegal (illegal_op)
   );

   assign req.req_ready = (state_reg == ST_RUN) && !full_o && rst_i;
   assign accept        = req.req_valid && req.req_ready;
   assign count_inc     = count_o + 1'b1;
   assign addr_cur      = ADDR_W'({count_o, 2'b00});

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_reg   <= ST_RUN;
         imem_we_o   <= 1'b0;
         imem_addr_o <= '0;
         imem_data_o <= '0;
         count_o     <= '0;
         full_o      <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         imem_we_o <= 1'b0;
         case (state_reg)
            ST_RUN: begin
               if (accept) begin
                  if (illegal_op) begin
                     err_o <= 1'b1;
                  end else begin
                     imem_we_o   <= 1'b1;
                     imem_addr_o <= addr_cur;
                     imem_data_o <= packed_word;
                     count_o     <= count_inc;
                     full_o      <= (count_inc == DEPTH_C);
                  end
               end
               if (req.finish) begin
`ifdef INSTR_ENCODER_NOP_PAD_EN
                  // Fullness must include a write accepted on this same edge
                  if (full_o || (accept && !illegal_op && count_inc == DEPTH_C)) begin
                     state_reg <= ST_DONE;
                     done_o    <= 1'b1;
                  end else begin
                     state_reg <= ST_PAD;
                  end
`else
                  state_reg <= ST_DONE;
                  done_o    <= 1'b1;
`endif
               end
            end
`ifdef INSTR_ENCODER_NOP_PAD_EN
            ST_PAD: begin
               // PAD is left on the write that fills memory, so it never sees full_o
               imem_we_o   <= 1'b1;
               imem_addr_o <= addr_cur;
               imem_data_o <= NOP_WORD;
               count_o     <= count_inc;
               full_o      <= (count_inc == DEPTH_C);
               if (count_inc == DEPTH_C) begin
                  state_reg <= ST_DONE;
                  done_o    <= 1'b1;
               end
            end
`endif
            default: begin
               state_reg <= state_reg;
            end
         endcase
      end
   end

endmodule
